// File: rtl/ap_arbiter.sv
// Round-robin arbiter sharing one ap_ctrl_hs HLS core among N_REQ requesters.
// One job in flight at a time; every output is driven straight from a flop.
module ap_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] job_count,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] OneHot0 = N_REQ'(1);

  typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               win_found;
  logic [IdxW-1:0]    win_idx;
  logic [IdxW-1:0]    cand;
  int unsigned        cand_int;
  logic               finish;

  // Round-robin search: first set request at or after ptr, wrapping to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_int  = 0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand_int = (32'(ptr_q) + i) % N_REQ;
      cand     = IdxW'(cand_int);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    finish  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ap_idle && win_found) begin
          state_d = StStart;
          owner_d = win_idx;
          grant_d = OneHot0 << win_idx;
          start_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StStart: begin
        if (ap_ready) begin
          start_d = 1'b0;
          if (ap_done) begin
            finish = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (ap_done) begin
          finish = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Completion: strobe the owner, release the grant, advance the pointer past it.
    if (finish) begin
      state_d = StDone;
      grant_d = '0;
      done_d  = OneHot0 << owner_q;
      cnt_d   = cnt_q + CNT_W'(1);
      ptr_d   = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + IdxW'(1);
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant      = grant_q;
  assign done_pulse = done_q;
  assign busy       = busy_q;
  assign ap_start   = start_q;
  assign job_count  = cnt_q;

endmodule

// File: tb/tb_ap_arbiter.sv
// Self-checking bench for ap_arbiter: directed jobs with randomized handshake timing,
// checked against a transaction-level round-robin model. A second instance with a
// 2-bit counter shares the stimulus to exercise counter wrap.
module tb_ap_arbiter;

  localparam int N = 4;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic        ap_idle = 1'b0;

  logic [3:0]  grant, done_pulse, grant_w, done_pulse_w;
  logic        busy, ap_start, busy_w, ap_start_w;
  logic [15:0] job_count;
  logic [1:0]  job_count_w;

  int compared = 0;
  int mismatched = 0;
  int m_ptr = 0;
  int m_count = 0;

  ap_arbiter #(.N_REQ(4), .CNT_W(16)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req(req), .grant(grant),
    .done_pulse(done_pulse), .busy(busy), .job_count(job_count), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle)
  );

  ap_arbiter #(.N_REQ(4), .CNT_W(2)) dut_w (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req(req), .grant(grant_w),
    .done_pulse(done_pulse_w), .busy(busy_w), .job_count(job_count_w), .ap_start(ap_start_w),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output of both instances against the expectation and the model count.
  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [3:0] ed,
                         input logic eb, input logic es);
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".done_pulse"}, 32'(done_pulse), 32'(ed));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".ap_start"}, 32'(ap_start), 32'(es));
    chk({tag, ".job_count"}, 32'(job_count), 32'(m_count % 65536));
    chk({tag, ".grant_w"}, 32'(grant_w), 32'(eg));
    chk({tag, ".done_pulse_w"}, 32'(done_pulse_w), 32'(ed));
    chk({tag, ".busy_w"}, 32'(busy_w), 32'(eb));
    chk({tag, ".ap_start_w"}, 32'(ap_start_w), 32'(es));
    chk({tag, ".job_count_w"}, 32'(job_count_w), 32'(m_count % 4));
  endtask

  // Model: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    int idx;
    for (int i = 0; i < N; i++) begin
      idx = (p + i) % N;
      if (r[idx[1:0]]) return idx;
    end
    return 0;
  endfunction

  // One complete job starting from IDLE at a negedge.
  task automatic do_job(input logic [3:0] r, input int idle_wait, input int ready_wait,
                        input int done_wait, input bit combined, input bit drop_req);
    int w;
    logic [3:0] oh;
    req = r;
    ap_idle = 1'b0;
    for (int i = 0; i < idle_wait; i++) begin
      ap_ready = 1'($urandom % 2);
      ap_done  = 1'($urandom % 2);
      @(negedge ap_clk);
      chk_all("idle_blocked", 4'h0, 4'h0, 1'b0, 1'b0);
    end
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    ap_idle  = 1'b1;
    w  = rr_pick(r, m_ptr);
    oh = 4'b0001 << w;
    @(negedge ap_clk);
    ap_idle = 1'b0;
    if (drop_req) req = 4'($urandom);
    chk_all("start", oh, 4'h0, 1'b1, 1'b1);
    for (int i = 0; i < ready_wait; i++) begin
      @(negedge ap_clk);
      if (drop_req) req = 4'($urandom);
      chk_all("start_hold", oh, 4'h0, 1'b1, 1'b1);
    end
    ap_ready = 1'b1;
    ap_done  = combined;
    @(negedge ap_clk);
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    if (combined) begin
      m_count++;
      chk_all("done_combined", 4'h0, oh, 1'b1, 1'b0);
    end else begin
      chk_all("run", oh, 4'h0, 1'b1, 1'b0);
      for (int i = 0; i < done_wait; i++) begin
        ap_ready = 1'($urandom % 2);
        @(negedge ap_clk);
        chk_all("run_hold", oh, 4'h0, 1'b1, 1'b0);
      end
      ap_ready = 1'b0;
      ap_done  = 1'b1;
      @(negedge ap_clk);
      ap_done = 1'b0;
      m_count++;
      chk_all("done", 4'h0, oh, 1'b1, 1'b0);
    end
    m_ptr = (w + 1) % N;
    // Requests and an idle core during the pulse cycle must not produce a grant yet.
    req = 4'hF;
    ap_idle = 1'b1;
    @(negedge ap_clk);
    chk_all("post_done", 4'h0, 4'h0, 1'b0, 1'b0);
    req = 4'h0;
    ap_idle = 1'b0;
  endtask

  initial begin
    ap_rst_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    chk_all("reset", 4'h0, 4'h0, 1'b0, 1'b0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk_all("release", 4'h0, 4'h0, 1'b0, 1'b0);

    // Single job: ready on third START cycle, done five cycles after ready.
    do_job(4'b0001, 0, 2, 4, 1'b0, 1'b0);
    chk("single_count", 32'(job_count), 32'd1);

    // Fairness with all requesters active.
    for (int j = 0; j < 8; j++) begin
      do_job(4'b1111, 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), 1'b0, 1'b0);
    end
    chk("fair_count", 32'(job_count), 32'd9);

    // Combined ready+done in the first START cycle.
    do_job(4'b1000, 0, 0, 0, 1'b1, 1'b0);

    // Core busy for ten cycles blocks the grant.
    do_job(4'b0100, 10, 1, 2, 1'b0, 1'b0);

    // Reset in RUN abandons the job.
    req = 4'b0010;
    ap_idle = 1'b1;
    @(negedge ap_clk);
    ap_idle = 1'b0;
    chk("pre_reset_grant", 32'(grant), 32'(4'b0001 << rr_pick(4'b0010, m_ptr)));
    ap_ready = 1'b1;
    @(negedge ap_clk);
    ap_ready = 1'b0;
    req = 4'h0;
    #2 ap_rst_n = 1'b0;
    m_count = 0;
    m_ptr = 0;
    #1 chk_all("async_reset", 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge ap_clk);
    ap_done = 1'b1;
    @(negedge ap_clk);
    chk_all("reset_hold", 4'h0, 4'h0, 1'b0, 1'b0);
    ap_done = 1'b0;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk_all("release2", 4'h0, 4'h0, 1'b0, 1'b0);
    do_job(4'b1010, 3, 1, 1, 1'b0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 30; j++) begin
      do_job(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
             1'($urandom % 4 == 0), 1'($urandom % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
